// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle MIPS main control FSM (fetch/decode/execute/mem/writeback)
module mc_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Illegal_Op,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t state;
    logic   pc_write;
    logic   branch;
    logic   legal_op;

    assign legal_op = (Opcode == OP_LW) || (Opcode == OP_SW) || (Opcode == OP_RTYPE) ||
                      (Opcode == OP_BEQ) || (Opcode == OP_ADDI) || (Opcode == OP_J);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    state <= S_DECODE;
                S_DECODE: begin
                    if ((Opcode == OP_LW) || (Opcode == OP_SW)) state <= S_MEMADR;
                    else if (Opcode == OP_RTYPE)                state <= S_EXECUTE;
                    else if (Opcode == OP_BEQ)                  state <= S_BRANCH;
                    else if (Opcode == OP_ADDI)                 state <= S_ADDIEX;
                    else if (Opcode == OP_J)                    state <= S_JUMP;
                    else                                        state <= S_FETCH;
                end
                S_MEMADR:   state <= (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= S_MEMWB;
                S_EXECUTE:  state <= S_ALUWB;
                S_ADDIEX:   state <= S_ADDIWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode the state directly and are held at zero while reset is high,
    // so an asynchronous reset kills any write strobe within the same cycle.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        Illegal_Op = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        if (!RST) begin
            case (state)
                S_FETCH: begin
                    ALUSrcB  = 2'b01;
                    IRWrite  = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    Illegal_Op = ~legal_op;
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMREAD:  IorD = 1'b1;
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    branch  = 1'b1;
                end
                S_ADDIWB:   RegWrite = 1'b1;
                S_JUMP: begin
                    PCSrc    = 2'b10;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PCEn  = pc_write | (branch & Zero);
    assign State = state;

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - table-driven self-checking bench for mc_main_control
module tb_mc_main_control;

    logic       CLK, RST, Zero;
    logic [5:0] Opcode;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal_Op;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] State;

    mc_main_control dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal_Op(Illegal_Op), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn,Illegal_Op}
    logic [14:0] outs;
    assign outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSrc, PCEn, Illegal_Op};

    localparam logic [14:0] E_ZERO   = 15'd0;
    localparam logic [14:0] E_FETCH  = {7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [14:0] E_DEC    = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_DECILL = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [14:0] E_ADR    = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MRD    = {7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MWB    = {7'b0000110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MWR    = {7'b1100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_EXE    = {7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_AWB    = {7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_BRZ    = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [14:0] E_BRNZ   = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
    localparam logic [14:0] E_IWB    = {7'b0000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_JMP    = {7'b0000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;
    int   rf_writes = 0;
    int   mem_writes = 0;

    always @(posedge CLK) begin
        if (RegWrite) rf_writes++;
        if (MemWrite) mem_writes++;
    end

    task automatic add(input logic r, input logic [5:0] o, input logic z,
                       input logic [3:0] s, input logic [14:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.st = s; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        int wr_before;
        RST = 1'b1; Opcode = 6'h00; Zero = 1'b0;

        repeat (3) add(1, 6'h00, 0, 4'd0, E_ZERO);
        // LW
        add(0, 6'h23, 0, 4'd0, E_FETCH); add(0, 6'h23, 0, 4'd1, E_DEC);
        add(0, 6'h23, 0, 4'd2, E_ADR);   add(0, 6'h23, 0, 4'd3, E_MRD);
        add(0, 6'h23, 0, 4'd4, E_MWB);
        // SW
        add(0, 6'h2B, 0, 4'd0, E_FETCH); add(0, 6'h2B, 0, 4'd1, E_DEC);
        add(0, 6'h2B, 0, 4'd2, E_ADR);   add(0, 6'h2B, 0, 4'd5, E_MWR);
        // R-type
        add(0, 6'h00, 0, 4'd0, E_FETCH); add(0, 6'h00, 0, 4'd1, E_DEC);
        add(0, 6'h00, 0, 4'd6, E_EXE);   add(0, 6'h00, 0, 4'd7, E_AWB);
        // BEQ taken / not taken
        add(0, 6'h04, 1, 4'd0, E_FETCH); add(0, 6'h04, 1, 4'd1, E_DEC);
        add(0, 6'h04, 1, 4'd8, E_BRZ);
        add(0, 6'h04, 0, 4'd0, E_FETCH); add(0, 6'h04, 0, 4'd1, E_DEC);
        add(0, 6'h04, 0, 4'd8, E_BRNZ);
        // ADDI
        add(0, 6'h08, 0, 4'd0, E_FETCH); add(0, 6'h08, 0, 4'd1, E_DEC);
        add(0, 6'h08, 0, 4'd9, E_ADR);   add(0, 6'h08, 0, 4'd10, E_IWB);
        // J
        add(0, 6'h02, 0, 4'd0, E_FETCH); add(0, 6'h02, 0, 4'd1, E_DEC);
        add(0, 6'h02, 0, 4'd11, E_JMP);
        // illegal opcodes
        add(0, 6'h3F, 0, 4'd0, E_FETCH); add(0, 6'h3F, 0, 4'd1, E_DECILL);
        add(0, 6'h05, 0, 4'd0, E_FETCH); add(0, 6'h05, 0, 4'd1, E_DECILL);
        add(0, 6'h00, 0, 4'd0, E_FETCH);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst; Opcode = vecs[i].op; Zero = vecs[i].zero;
            #1;
            chk($sformatf("state[%0d]", i), 32'(State), 32'(vecs[i].st));
            chk($sformatf("outs[%0d]", i), 32'(outs), 32'(vecs[i].exp));
        end
        chk("rf_write_count", rf_writes, 3);
        chk("mem_write_count", mem_writes, 1);

        // reset mid-LW while in MEMWB
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0; Opcode = 6'h23;
        repeat (4) @(negedge CLK);
        #1;
        chk("midlw_state", 32'(State), 32'd4);
        chk("midlw_regwrite", 32'(RegWrite), 32'd1);
        wr_before = rf_writes;
        #2 RST = 1'b1;
        #1;
        chk("midlw_rst_state", 32'(State), 32'd0);
        chk("midlw_rst_regwrite", 32'(RegWrite), 32'd0);
        chk("midlw_rst_pcen", 32'(PCEn), 32'd0);
        @(posedge CLK); #1;
        chk("midlw_no_commit", rf_writes, wr_before);

        // BEQ: Zero rising mid-cycle drives PCEn combinationally
        @(negedge CLK); RST = 1'b0; Opcode = 6'h04; Zero = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("beq_state", 32'(State), 32'd8);
        chk("beq_pcen_z0", 32'(PCEn), 32'd0);
        Zero = 1'b1;
        #1;
        chk("beq_pcen_z1", 32'(PCEn), 32'd1);
        @(negedge CLK); #1;
        chk("beq_back_fetch", 32'(State), 32'd0);

        // Illegal_Op follows Opcode combinationally in DECODE
        Opcode = 6'h3F;
        @(negedge CLK); #1;
        chk("ill_dec", 32'(Illegal_Op), 32'd1);
        Opcode = 6'h23;
        #1;
        chk("ill_dec_legal", 32'(Illegal_Op), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
